sprite_bank: RTL and testbench

SPRITE_BANK -- requirements
Module: sprite_bank

---
 rtl/sprite_pkg.sv | 32 +++
 rtl/sprite_bank_if.sv | 27 ++
 rtl/sprite_rom_pair.sv | 27 ++
 rtl/sprite_bank.sv | 135 +++++++++++++
 tb/tb_sprite_bank.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the LED sprite bank.
// Holds the RGB565 pixel type, blink state enum, default geometry and the sprite art.
// Sprite art is generated from the address so both ROMs stay synthesizable without init files.
package sprite_pkg;

  localparam int DEF_N_LEDS   = 13;
  localparam int DEF_SPR_BITS = 5;
  localparam int DEF_X0       = 32;
  localparam int DEF_Y0       = 96;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic {
    SHOW = 1'b0,
    HIDE = 1'b1
  } blink_state_t;

  // Lit sprite: red base with the address pattern folded into the low bits.
  function automatic rgb565_t spr_on_word(input logic [15:0] addr);
    return rgb565_t'(16'hF800 ^ addr);
  endfunction

  // Unlit sprite: dim grey base with the same address pattern.
  function automatic rgb565_t spr_off_word(input logic [15:0] addr);
    return rgb565_t'(16'h0841 ^ addr);
  endfunction

endpackage

// File: rtl/sprite_bank_if.sv
// Pixel-stream interface of the sprite bank: scan coordinates, frame pulse, LED requests, RGB out.
// No latency of its own; purely a bundle of wires.
// No backpressure: the pixel stream is free-running.
interface sprite_bank_if #(
  parameter int N_LEDS = 13
);
  logic [8:0]        i_x;
  logic [8:0]        i_y;
  logic              i_de;
  logic              i_frame;
  logic [N_LEDS-1:0] i_status;
  logic [N_LEDS-1:0] i_blink;
  logic [4:0]        o_r;
  logic [5:0]        o_g;
  logic [4:0]        o_b;
  logic              o_de;

  modport master (
    output i_x, i_y, i_de, i_frame, i_status, i_blink,
    input  o_r, o_g, o_b, o_de
  );

  modport slave (
    input  i_x, i_y, i_de, i_frame, i_status, i_blink,
    output o_r, o_g, o_b, o_de
  );
endinterface

// File: rtl/sprite_rom_pair.sv
// On-sprite and off-sprite ROMs sharing one address, read in parallel.
// Latency: 1 cycle from i_addr to o_on/o_off.
// No backpressure: a new address is accepted every cycle.
module sprite_rom_pair
  import sprite_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_addr,
  output rgb565_t       o_on,
  output rgb565_t       o_off
);

  // Registered read of both sprite images at the shared address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_on  <= '0;
      o_off <= '0;
    end else begin
      o_on  <= spr_on_word(16'(i_addr));
      o_off <= spr_off_word(16'(i_addr));
    end
  end

endmodule

// File: rtl/sprite_bank.sv
// Draws a row of N_LEDS sprites at (X0,Y0), each LED picking its on/off image; blinking optional via SPRITE_BANK_BLINK_EN.
// Latency: 2 cycles from i_x/i_y/i_de to RGB/o_de.
// No backpressure: free-running pixel pipeline; LED requests only change at the i_frame pulse.
module sprite_bank
  import sprite_pkg::*;
#(
  parameter int N_LEDS       = DEF_N_LEDS,
  parameter int SPR_BITS     = DEF_SPR_BITS,
  parameter int X0           = DEF_X0,
  parameter int Y0           = DEF_Y0,
  parameter int BLINK_FRAMES = 30
) (
  input logic          i_clk,
  input logic          i_rst_n,
  sprite_bank_if.slave bus
);

  localparam int SPR_W = 1 << SPR_BITS;
  localparam int X_END = X0 + N_LEDS * SPR_W - 1;
  localparam int Y_END = Y0 + SPR_W - 1;
  localparam int AW    = 2 * SPR_BITS;

  // 16-bit window arithmetic so coordinates left of / above the origin never wrap into range.
  logic [15:0]       x_ext, y_ext, dx, dy;
  logic              in_win;
  logic [3:0]        led_k, led_idx;
  logic [AW-1:0]     rom_addr;
  logic [N_LEDS-1:0] shadow_status, lit_vec;
  logic [15:0]       lit_pad;
  logic              shadow_vld;
  logic              s1_de, s1_show, s1_lit;
  logic              de_q;
  rgb565_t           on_px, off_px, rgb_q;
  logic              unused_bits;

  assign x_ext    = {7'd0, bus.i_x};
  assign y_ext    = {7'd0, bus.i_y};
  assign dx       = x_ext - 16'(X0);
  assign dy       = y_ext - 16'(Y0);
  assign in_win   = (x_ext >= 16'(X0)) && (x_ext <= 16'(X_END)) &&
                    (y_ext >= 16'(Y0)) && (y_ext <= 16'(Y_END));
  assign led_k    = dx[SPR_BITS +: 4];
  // Leftmost LED (k=0) is the MSB of the status vector.
  assign led_idx  = 4'(N_LEDS - 1) - led_k;
  assign rom_addr = {dy[SPR_BITS-1:0], dx[SPR_BITS-1:0]};
  assign lit_pad  = 16'(lit_vec);
  assign unused_bits = ^{dx, dy};

  // Latch LED requests once per frame; shadow_vld keeps the row black until the first load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_status <= '0;
      shadow_vld    <= 1'b0;
    end else if (bus.i_frame) begin
      shadow_status <= bus.i_status;
      shadow_vld    <= 1'b1;
    end
  end

`ifdef SPRITE_BANK_BLINK_EN
  logic [N_LEDS-1:0] shadow_blink;
  blink_state_t      blink_st;
  logic [15:0]       frm_cnt;

  // Blink requests follow the same per-frame capture as the status bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_blink <= '0;
    end else if (bus.i_frame) begin
      shadow_blink <= bus.i_blink;
    end
  end

  // Blink FSM: toggles every BLINK_FRAMES frame pulses, in the same cycle as the shadow capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_st <= SHOW;
      frm_cnt  <= '0;
    end else if (bus.i_frame) begin
      if (frm_cnt == 16'(BLINK_FRAMES - 1)) begin
        frm_cnt  <= '0;
        blink_st <= (blink_st == SHOW) ? HIDE : SHOW;
      end else begin
        frm_cnt <= frm_cnt + 16'd1;
      end
    end
  end

  assign lit_vec = shadow_status & (~shadow_blink | {N_LEDS{blink_st == SHOW}});
`else
  logic unused_blink;
  localparam int unused_blink_frames = BLINK_FRAMES;

  assign unused_blink = ^bus.i_blink;
  assign lit_vec      = shadow_status;
`endif

  // Stage 1: window/enable decision and LED select, aligned with the ROM read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_de   <= 1'b0;
      s1_show <= 1'b0;
      s1_lit  <= 1'b0;
    end else begin
      s1_de   <= bus.i_de;
      s1_show <= bus.i_de & in_win & shadow_vld;
      s1_lit  <= lit_pad[led_idx];
    end
  end

  sprite_rom_pair #(.AW(AW)) u_rom (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_addr  (rom_addr),
    .o_on    (on_px),
    .o_off   (off_px)
  );

  // Stage 2: choose on/off image, black outside the window or when not displaying.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
    end else begin
      de_q  <= s1_de;
      rgb_q <= s1_show ? (s1_lit ? on_px : off_px) : '0;
    end
  end

  assign bus.o_r  = rgb_q.r;
  assign bus.o_g  = rgb_q.g;
  assign bus.o_b  = rgb_q.b;
  assign bus.o_de = de_q;

endmodule

// File: tb/tb_sprite_bank.sv
// Scoreboard bench for sprite_bank: the driver queues the expected pixel per issued coordinate,
// a monitor compares it against the DUT output two cycles later.
// Reset and blink sequences are checked with directed, hand-computed vectors.
module tb_sprite_bank;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  sprite_bank_if #(.N_LEDS(13)) bus ();

  sprite_bank #(
    .N_LEDS       (13),
    .SPR_BITS     (5),
    .X0           (32),
    .Y0           (96),
    .BLINK_FRAMES (2)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  typedef struct {
    int          stamp;
    logic        de;
    logic [15:0] rgb;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] mon_rgb;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: an entry stamped at cycle k is due on the outputs after posedge k+2.
  always @(posedge i_clk) begin
    #1;
    while (q.size() > 0 && q[0].stamp <= cyc - 2) begin
      mon_e   = q.pop_front();
      mon_rgb = {bus.o_r, bus.o_g, bus.o_b};
      total++;
      if (bus.o_de !== mon_e.de || mon_rgb !== mon_e.rgb) begin
        bad++;
        $display("FAIL %s: got de=%0b rgb=%h, want de=%0b rgb=%h",
                 mon_e.name, bus.o_de, mon_rgb, mon_e.de, mon_e.rgb);
      end
    end
  end

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  task automatic px(input int x, input int y, input logic de, input logic [15:0] rgb,
                    input string nm);
    @(negedge i_clk);
    bus.i_x  = 9'(x);
    bus.i_y  = 9'(y);
    bus.i_de = de;
    q.push_back('{cyc, de, rgb, nm});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      bus.i_de    = 1'b0;
      bus.i_frame = 1'b0;
    end
  endtask

  task automatic frame();
    @(negedge i_clk);
    bus.i_de    = 1'b0;
    bus.i_frame = 1'b1;
    @(negedge i_clk);
    bus.i_frame = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    bus.i_de = 1'b0;
    q.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  logic lit_exp [5];

  initial begin
    bus.i_x      = '0;
    bus.i_y      = '0;
    bus.i_de     = 1'b0;
    bus.i_frame  = 1'b0;
    bus.i_status = '0;
    bus.i_blink  = '0;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", {bus.o_de, bus.o_r, bus.o_g, bus.o_b}, 17'h0);
    i_rst_n = 1'b1;

    // No shadow load yet: the window stays black.
    px(32, 96, 1'b1, 16'h0000, "pre_frame_black");
    idle(2);

    bus.i_status = 13'h1FFF;
    frame();
    px(32, 96, 1'b1, 16'hF800, "first_px_on_w0");
    px(33, 97, 1'b1, 16'hF821, "px_33_97_on_w33");
    px(31, 100, 1'b1, 16'h0000, "left_of_window");
    px(448, 100, 1'b1, 16'h0000, "right_of_window");
    px(40, 128, 1'b1, 16'h0000, "below_window");
    px(40, 95, 1'b1, 16'h0000, "above_window");
    px(447, 127, 1'b1, 16'hFBFF, "last_px_on_w1023");
    px(50, 100, 1'b0, 16'h0000, "de_low_in_window");
    idle(3);

    // Mid-frame status change must not show until the next frame pulse.
    bus.i_status = 13'h0000;
    frame();
    px(32, 96, 1'b1, 16'h0841, "status0_off_w0");
    bus.i_status = 13'h1000;
    px(32, 96, 1'b1, 16'h0841, "midframe_change_hidden");
    idle(2);
    frame();
    px(32, 96, 1'b1, 16'hF800, "left_led_on_after_frame");
    px(64, 96, 1'b1, 16'h0841, "second_led_off");
    px(447, 127, 1'b1, 16'h0BBE, "last_px_off_w1023");
    idle(3);

    // Reset pulled mid-line while a lit pixel is on the outputs.
    bus.i_status = 13'h1FFF;
    frame();
    px(32, 96, 1'b1, 16'hF800, "pre_reset_px");
    px(33, 96, 1'b1, 16'hF801, "pre_reset_px2");
    @(negedge i_clk);
    i_rst_n = 1'b0;
    q.delete();
    #1;
    chk("reset_midline_zero", {bus.o_de, bus.o_r, bus.o_g, bus.o_b}, 17'h0);
    bus.i_de = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    px(32, 96, 1'b1, 16'h0000, "post_reset_black");
    px(447, 127, 1'b1, 16'h0000, "post_reset_black_last");
    idle(2);
    frame();
    px(32, 96, 1'b1, 16'hF800, "post_reset_frame_on");
    idle(3);

    // Blink: three priming pulses leave the FSM at the end of a HIDE half-period,
    // so the next five pulses start a fresh SHOW half-period: on,on,off,off,on.
    do_reset();
    bus.i_status = 13'h0000;
    bus.i_blink  = 13'h0000;
    repeat (3) frame();
    bus.i_status = 13'h0001;
    bus.i_blink  = 13'h0001;
`ifdef SPRITE_BANK_BLINK_EN
    lit_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    lit_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int f = 0; f < 5; f++) begin
      frame();
      px(447, 96, 1'b1, lit_exp[f] ? 16'hF81F : 16'h085E, $sformatf("blink_frame%0d", f + 1));
      idle(2);
    end

    idle(4);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
